pc_unit: RTL

- Parametrised program counter for the fetch stage of the MIPS datapath.
- Holds the current fetch address and advances it by a configurable step each cycle.
- Accepts branch, jump and exception redirects with fixed priority, and supports pipeline stalls.
- Buffers a redirect that arrives during a stall so it is not lost; drives instruction memory and the debug/display path.

---
 rtl/pc_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// pc_unit -- fetch-stage program counter for the MIPS datapath.
//
// Holds the current fetch address. Each cycle it either advances by STEP or
// takes a redirect. Redirects are chosen by fixed priority: exception, then
// jump, then branch. A redirect that arrives while the pipeline is stalled is
// parked in a pending register and applied when the stall is released.
//
// Optional feature: define PC_TRACE_EN to build a circular trace buffer that
// records the last TRACE_DEPTH PC values the counter moved away from. Without
// the macro no trace storage exists and TraceData is constant zero.
//
// Ports:
//   Clk          rising-edge clock
//   Reset        asynchronous active-high reset
//   Stall        hold the PC (hazard unit)
//   BranchTaken  branch redirect request, target BranchTarget
//   JumpTaken    jump redirect request, target JumpTarget
//   ExcReq       exception redirect request, target EXC_VECTOR
//   PCResult     registered current PC
//   PCPlusStep   PCResult + STEP (wraps modulo 2^WIDTH)
//   Pending      a redirect is buffered until the stall clears
//   AlignErr     one-cycle pulse: a misaligned jump/branch target was rejected
//   debugPC      copy of PCResult for the debug/display path
//   TraceIdx     trace read index, 0 = most recent departed PC
//   TraceData    trace read data (0 when PC_TRACE_EN is undefined)
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter int               STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h00000000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h00000080,
  parameter int               TRACE_DEPTH  = 8
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           Stall,
  input  logic                           BranchTaken,
  input  logic [WIDTH-1:0]               BranchTarget,
  input  logic                           JumpTaken,
  input  logic [WIDTH-1:0]               JumpTarget,
  input  logic                           ExcReq,
  output logic [WIDTH-1:0]               PCResult,
  output logic [WIDTH-1:0]               PCPlusStep,
  output logic                           Pending,
  output logic                           AlignErr,
  output logic [WIDTH-1:0]               debugPC,
  input  logic [$clog2(TRACE_DEPTH)-1:0] TraceIdx,
  output logic [WIDTH-1:0]               TraceData
);

  localparam int               IDX_W      = $clog2(TRACE_DEPTH);
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = STEP_W - WIDTH'(1);

  // Ordered so that a numerically larger value is a stronger redirect.
  typedef enum logic [1:0] {PRI_NONE, PRI_BRANCH, PRI_JUMP, PRI_EXC} prio_t;
  typedef enum logic {RUN, HOLD} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pendTarget;
  prio_t            r_pendPri;
  logic             r_pending;
  logic             r_alignErr;

  prio_t            w_reqPri;
  logic [WIDTH-1:0] w_reqTarget;
  logic             w_misaligned;
  logic             w_takeNew;
  logic [WIDTH-1:0] w_nextPc;

  // Pick this cycle's redirect. A misaligned jump/branch keeps its priority
  // class but is steered to the exception vector instead.
  always_comb begin
    w_reqPri     = PRI_NONE;
    w_reqTarget  = EXC_VECTOR;
    w_misaligned = 1'b0;
    if (ExcReq) begin
      w_reqPri = PRI_EXC;
    end else if (JumpTaken) begin
      w_reqPri     = PRI_JUMP;
      w_misaligned = (JumpTarget & ALIGN_MASK) != '0;
      w_reqTarget  = w_misaligned ? EXC_VECTOR : JumpTarget;
    end else if (BranchTaken) begin
      w_reqPri     = PRI_BRANCH;
      w_misaligned = (BranchTarget & ALIGN_MASK) != '0;
      w_reqTarget  = w_misaligned ? EXC_VECTOR : BranchTarget;
    end
  end

  // In RUN the buffered priority is always PRI_NONE, so any request wins;
  // in HOLD a request only displaces an equal-or-weaker buffered one.
  assign w_takeNew = (w_reqPri != PRI_NONE) && (w_reqPri >= r_pendPri);

  always_comb begin
    w_nextPc = r_pc;
    if (!Stall) begin
      if (r_state == HOLD) begin
        w_nextPc = w_takeNew ? w_reqTarget : r_pendTarget;
      end else begin
        w_nextPc = w_takeNew ? w_reqTarget : r_pc + STEP_W;
      end
    end
  end

  // RUN/HOLD controller with all outputs registered.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= RUN;
      r_pc         <= RESET_VECTOR;
      r_pendTarget <= '0;
      r_pendPri    <= PRI_NONE;
      r_pending    <= 1'b0;
      r_alignErr   <= 1'b0;
    end else begin
      r_pc       <= w_nextPc;
      r_alignErr <= w_misaligned;
      if (Stall) begin
        if (w_takeNew) begin
          r_pendTarget <= w_reqTarget;
          r_pendPri    <= w_reqPri;
          r_state      <= HOLD;
          r_pending    <= 1'b1;
        end
      end else begin
        r_pendTarget <= '0;
        r_pendPri    <= PRI_NONE;
        r_state      <= RUN;
        r_pending    <= 1'b0;
      end
    end
  end

  assign PCResult   = r_pc;
  assign debugPC    = r_pc;
  assign PCPlusStep = r_pc + STEP_W;
  assign Pending    = r_pending;
  assign AlignErr   = r_alignErr;

`ifdef PC_TRACE_EN
  logic [WIDTH-1:0] r_trace [TRACE_DEPTH];
  logic [IDX_W-1:0] r_wptr;
  logic [IDX_W-1:0] w_rdPtr;

  // Record the PC being left whenever the PC actually changes value.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        r_trace[i] <= '0;
      end
      r_wptr <= '0;
    end else if (w_nextPc != r_pc) begin
      r_trace[r_wptr] <= r_pc;
      r_wptr          <= r_wptr + IDX_W'(1);
    end
  end

  // Index 0 is the newest entry; pointer arithmetic wraps at TRACE_DEPTH.
  assign w_rdPtr   = r_wptr - IDX_W'(1) - TraceIdx;
  assign TraceData = r_trace[w_rdPtr];
`else
  logic [IDX_W-1:0] w_unusedTraceIdx;
  assign w_unusedTraceIdx = TraceIdx;
  assign TraceData        = '0;
`endif

endmodule
